// File: rtl/weight_fetch_unit.sv
// Weight FIFO producer: streams weight tile rows from memory into the weight FIFO,
// using a credit count (occupancy + reads in flight) so the FIFO can never overflow.
module weight_fetch_unit #(
    parameter int MUL_SIZE    = 32,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int TILE_W      = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instruction_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [TILE_W-1:0]            num_tiles_i,
    output logic                         mem_rd_en_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    input  logic [MUL_SIZE*DATA_W-1:0]   mem_rdata_i,
    output logic                         weight_fifo_wr_en_o,
    output logic [MUL_SIZE*DATA_W-1:0]   weight_fifo_wdata_o,
    input  logic                         weight_fifo_pop_i,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int TOT_W = TILE_W + $clog2(MUL_SIZE);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Valid pipe shifts toward the MSB; the MSB marks the row arriving from memory.
    localparam logic [MEM_LATENCY-1:0] TAIL_MASK = MEM_LATENCY'(1) << (MEM_LATENCY - 1);

    logic [1:0]                   r_state;
    logic [ADDR_W-1:0]            r_base;
    logic [TOT_W-1:0]             r_total;
    logic [TOT_W-1:0]             r_row;
    logic [CNT_W-1:0]             r_inflight;
    logic [CNT_W-1:0]             r_occ;
    logic [MEM_LATENCY-1:0]       r_vpipe;
    logic                         r_wr_en;
    logic [MUL_SIZE*DATA_W-1:0]   r_wdata;
    logic                         r_done;

    logic [TOT_W-1:0]             w_total;
    logic                         w_credit_ok;
    logic                         w_issue;
    logic                         w_last_issue;
    logic                         w_tail;
    logic                         w_upstream;
    logic                         w_pop_eff;

    assign w_total      = TOT_W'(num_tiles_i) * TOT_W'(MUL_SIZE);
    assign w_credit_ok  = ((CNT_W+1)'(r_occ) + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(FIFO_DEPTH);
    assign w_issue      = (r_state == S_FETCH) && w_credit_ok;
    assign w_last_issue = w_issue && (r_row == r_total - TOT_W'(1));
    assign w_tail       = r_vpipe[MEM_LATENCY-1];
    assign w_upstream   = |(r_vpipe & ~TAIL_MASK);
    assign w_pop_eff    = weight_fifo_pop_i && (r_occ != '0);

    assign mem_rd_en_o         = w_issue;
    assign mem_addr_o          = r_base + ADDR_W'(r_row);
    assign weight_fifo_wr_en_o = r_wr_en;
    assign weight_fifo_wdata_o = r_wdata;
    assign busy_o              = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done_o              = r_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_total    <= '0;
            r_row      <= '0;
            r_inflight <= '0;
            r_occ      <= '0;
            r_vpipe    <= '0;
            r_wr_en    <= 1'b0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_vpipe <= (r_vpipe << 1) | MEM_LATENCY'(w_issue);
            r_wr_en <= w_tail;
            if (w_tail) begin
                r_wdata <= mem_rdata_i;
            end
            r_done <= (r_state == S_DONE);

            // A row stays counted in flight until it is actually pushed, so credits never leak.
            unique case ({w_issue, r_wr_en})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase

            unique case ({r_wr_en, w_pop_eff})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase

            unique case (r_state)
                S_IDLE: begin
                    if (instruction_i) begin
                        r_base  <= base_addr_i;
                        r_total <= w_total;
                        r_row   <= '0;
                        r_state <= (w_total == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_issue) begin
                        r_row <= r_row + TOT_W'(1);
                    end
                    if (w_last_issue) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave when the final row is at the pipe tail, so done trails the last push by one cycle.
                    if (w_tail && !w_upstream) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
